// File: rtl/stage_sequencer.sv
// Handshaked one-hot instruction-phase sequencer (IF->ID->EX->MEM->WB) with MEM skip, halt, per-stage watchdog and retire counter.
// Optional single-step launch control is enabled by defining SINGLE_STEP_EN; all outputs are registered.
module stage_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic [4:0]       stage_done,
    input  logic             skip_mem,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [4:0]       stage_en,
    output logic [4:0]       stage_start,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       fault_stage,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam int               TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TO_LAST_I);
    localparam bit               WD_EN     = (TIMEOUT > 0);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [2:0]         fault_stage_q, fault_stage_d;
    logic [4:0]         stage_en_q, stage_en_d;
    logic [4:0]         stage_start_q, stage_start_d;
    logic               busy_q, halted_q, fault_q;

    logic               in_stage;
    logic               cur_done;
    logic [2:0]         cur_idx;
    logic               launch;
    logic               chain_ok;

    // Single-step mode: each instruction needs its own step pulse from IDLE.
`ifdef SINGLE_STEP_EN
    assign launch   = run & step;
    assign chain_ok = 1'b0;
`else
    assign launch   = run;
    assign chain_ok = 1'b1;
`endif

    always_comb begin
        in_stage = 1'b0;
        cur_done = 1'b0;
        cur_idx  = 3'd0;
        case (state_q)
            ST_IF:  begin in_stage = 1'b1; cur_done = stage_done[0]; cur_idx = 3'd0; end
            ST_ID:  begin in_stage = 1'b1; cur_done = stage_done[1]; cur_idx = 3'd1; end
            ST_EX:  begin in_stage = 1'b1; cur_done = stage_done[2]; cur_idx = 3'd2; end
            ST_MEM: begin in_stage = 1'b1; cur_done = stage_done[3]; cur_idx = 3'd3; end
            ST_WB:  begin in_stage = 1'b1; cur_done = stage_done[4]; cur_idx = 3'd4; end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        halt_pend_d   = halt_pend_q;
        retired_d     = retired_q;
        fault_stage_d = fault_stage_q;

        case (state_q)
            ST_IDLE: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (launch) begin
                    state_d = ST_IF;
                end
            end
            ST_IF:  if (cur_done) state_d = ST_ID;
            ST_ID:  if (cur_done) state_d = ST_EX;
            ST_EX:  if (cur_done) state_d = skip_mem ? ST_WB : ST_MEM;
            ST_MEM: if (cur_done) state_d = ST_WB;
            ST_WB: begin
                if (cur_done) begin
                    retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (halt_pend_q || halt_req) begin
                        state_d = ST_HALT;
                    end else if (run && chain_ok) begin
                        state_d = ST_IF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        // A completion in the last allowed cycle beats the timeout.
        if (in_stage) begin
            if (halt_req) begin
                halt_pend_d = 1'b1;
            end
            if (!cur_done) begin
                if (WD_EN && (timer_q == TO_LAST)) begin
                    state_d       = ST_FAULT;
                    fault_stage_d = cur_idx;
                end else begin
                    timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end
        if (state_d == ST_HALT) begin
            halt_pend_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        stage_en_d = 5'b00000;
        case (state_d)
            ST_IF:   stage_en_d = 5'b00001;
            ST_ID:   stage_en_d = 5'b00010;
            ST_EX:   stage_en_d = 5'b00100;
            ST_MEM:  stage_en_d = 5'b01000;
            ST_WB:   stage_en_d = 5'b10000;
            default: stage_en_d = 5'b00000;
        endcase
        stage_start_d = (state_d != state_q) ? stage_en_d : 5'b00000;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            halt_pend_q   <= 1'b0;
            retired_q     <= '0;
            fault_stage_q <= 3'd0;
            stage_en_q    <= 5'b00000;
            stage_start_q <= 5'b00000;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            halt_pend_q   <= halt_pend_d;
            retired_q     <= retired_d;
            fault_stage_q <= fault_stage_d;
            stage_en_q    <= stage_en_d;
            stage_start_q <= stage_start_d;
            busy_q        <= |stage_en_d;
            halted_q      <= (state_d == ST_HALT);
            fault_q       <= (state_d == ST_FAULT);
        end
    end

    assign stage_en    = stage_en_q;
    assign stage_start = stage_start_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: two instances (TIMEOUT=64 and TIMEOUT=8) against an
// abstract per-instruction reference model, plus directed scenario checks.
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       run = 1'b0;
    logic       halt_req = 1'b0;
    logic       skip_mem = 1'b0;
    logic [4:0] stage_done = 5'b00000;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b1;
    localparam bit CHAIN = 1'b0;
`else
    localparam bit CHAIN = 1'b1;
`endif

    logic [4:0]  en0, st0, en1, st1;
    logic        busy0, hlt0, flt0, busy1, hlt1, flt1;
    logic [2:0]  fs0, fs1;
    logic [15:0] ret0, ret1;
    logic [31:0] dout [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_sequencer #(.CNT_W(16), .TIMEOUT(64), .TMR_W(8)) dut (
        .clk(clk), .n_reset(n_reset), .run(run), .halt_req(halt_req),
        .stage_done(stage_done), .skip_mem(skip_mem),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .stage_en(en0), .stage_start(st0), .busy(busy0), .halted(hlt0),
        .fault(flt0), .fault_stage(fs0), .retired(ret0)
    );

    stage_sequencer #(.CNT_W(16), .TIMEOUT(8), .TMR_W(8)) dut8 (
        .clk(clk), .n_reset(n_reset), .run(run), .halt_req(halt_req),
        .stage_done(stage_done), .skip_mem(skip_mem),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .stage_en(en1), .stage_start(st1), .busy(busy1), .halted(hlt1),
        .fault(flt1), .fault_stage(fs1), .retired(ret1)
    );

    assign dout[0] = {en0, st0, busy0, hlt0, flt0, fs0, ret0};
    assign dout[1] = {en1, st1, busy1, hlt1, flt1, fs1, ret1};

    // Model position: -1 idle, 0..4 = IF..WB, 5 halted, 6 faulted.
    int m_st  [2] = '{-1, -1};
    int m_dw  [2] = '{0, 0};
    int m_fs  [2] = '{0, 0};
    int m_ret [2] = '{0, 0};
    bit m_hp  [2] = '{0, 0};
    bit m_new [2] = '{0, 0};

    function automatic int to_of(input int k);
        return (k == 0) ? 64 : 8;
    endfunction

    function automatic bit step_ok();
`ifdef SINGLE_STEP_EN
        return step;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step(input int k);
        int nxt;
        nxt = m_st[k];
        m_new[k] = 1'b0;
        if (m_st[k] == -1) begin
            if (halt_req) nxt = 5;
            else if (run && step_ok()) nxt = 0;
        end else if (m_st[k] <= 4) begin
            if (halt_req) m_hp[k] = 1'b1;
            if (stage_done[m_st[k]]) begin
                if (m_st[k] == 2) begin
                    nxt = skip_mem ? 4 : 3;
                end else if (m_st[k] == 4) begin
                    m_ret[k] = (m_ret[k] + 1) % 65536;
                    nxt = m_hp[k] ? 5 : ((run && CHAIN) ? 0 : -1);
                end else begin
                    nxt = m_st[k] + 1;
                end
            end else begin
                m_dw[k] = m_dw[k] + 1;
                if (to_of(k) != 0 && m_dw[k] == to_of(k)) begin
                    nxt = 6;
                    m_fs[k] = m_st[k];
                end
            end
        end
        if (nxt != m_st[k]) begin
            m_dw[k] = 0;
            m_new[k] = (nxt >= 0 && nxt <= 4);
            if (nxt == 5) m_hp[k] = 1'b0;
        end
        m_st[k] = nxt;
    endtask

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k] = -1; m_dw[k] = 0; m_fs[k] = 0;
                m_ret[k] = 0; m_hp[k] = 1'b0; m_new[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    function automatic logic [31:0] mexp(input int k);
        logic [4:0] en;
        en = (m_st[k] >= 0 && m_st[k] <= 4) ? 5'(1 << m_st[k]) : 5'd0;
        return {en, (m_new[k] ? en : 5'd0), |en, (m_st[k] == 5), (m_st[k] == 6),
                3'(m_fs[k]), 16'(m_ret[k])};
    endfunction

    task automatic do_reset();
        n_reset = 1'b0;
        run = 1'b0; halt_req = 1'b0; skip_mem = 1'b0; stage_done = 5'b00000;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 32'd0) begin
                failures++;
                $display("FAIL reset_values[%0d]: got %h want 00000000", k, dout[k]);
            end
        end
        n_reset = 1'b1;
    endtask

    task automatic test_sequence();
        do_reset();
        run = 1'b1; stage_done = 5'b11111;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== mexp(k)) begin
                    failures++;
                    $display("FAIL sequence[%0d] cyc %0d: got %h want %h", k, c, dout[k], mexp(k));
                end
            end
`ifndef SINGLE_STEP_EN
            if (c == 21) begin
                checks++;
                if (ret0 !== 16'd4) begin
                    failures++;
                    $display("FAIL sequence_retired: got %0d want 4", ret0);
                end
            end
`endif
        end
    endtask

    task automatic test_skip_mem();
        do_reset();
        run = 1'b1; stage_done = 5'b11111; skip_mem = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== mexp(k)) begin
                    failures++;
                    $display("FAIL skip_mem[%0d] cyc %0d: got %h want %h", k, c, dout[k], mexp(k));
                end
            end
            checks++;
            if (en0[3] !== 1'b0) begin
                failures++;
                $display("FAIL skip_mem_no_mem cyc %0d: stage_en=%b", c, en0);
            end
`ifndef SINGLE_STEP_EN
            if (c == 17) begin
                checks++;
                if (ret0 !== 16'd4) begin
                    failures++;
                    $display("FAIL skip_mem_period: retired=%0d want 4", ret0);
                end
            end
`endif
        end
        skip_mem = 1'b0;
    endtask

    task automatic test_if_delay();
        do_reset();
        run = 1'b1; stage_done = 5'b00000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== mexp(k)) begin
                    failures++;
                    $display("FAIL if_delay[%0d] cyc %0d: got %h want %h", k, c, dout[k], mexp(k));
                end
            end
            checks++;
            if (c <= 11) begin
                if ({en0, st0[0], flt0} !== {5'b00001, (c == 1), 1'b0}) begin
                    failures++;
                    $display("FAIL if_hold cyc %0d: en=%b start0=%b fault=%b", c, en0, st0[0], flt0);
                end
            end else if ({en0, flt0} !== {5'b00010, 1'b0}) begin
                failures++;
                $display("FAIL if_release: en=%b fault=%b want 00010/0", en0, flt0);
            end
            if (c == 11) stage_done = 5'b00001;
        end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1; stage_done = 5'b11111;
        @(negedge clk);
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== mexp(k)) begin
                    failures++;
                    $display("FAIL halt[%0d] cyc %0d: got %h want %h", k, c, dout[k], mexp(k));
                end
            end
        end
        checks++;
        if ({hlt0, en0, busy0, ret0} !== {1'b1, 5'b00000, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL halt_final: halted=%b en=%b busy=%b retired=%0d", hlt0, en0, busy0, ret0);
        end
    endtask

    task automatic reach_mem();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (en1 !== 5'b01000 && n < 20);
        checks++;
        if (en1 !== 5'b01000) begin
            failures++;
            $display("FAIL reach_mem: stage_en=%b after %0d cycles", en1, n);
        end
    endtask

    task automatic test_watchdog();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            run = 1'b1; stage_done = 5'b00111;
            reach_mem();
            for (int mc = 1; mc <= 9; mc++) begin
                if (mc > 1) @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (dout[k] !== mexp(k)) begin
                        failures++;
                        $display("FAIL watchdog[%0d] v%0d mc %0d: got %h want %h", k, v, mc, dout[k], mexp(k));
                    end
                end
                checks++;
                if (v == 0 && mc == 9) begin
                    if ({flt1, fs1, busy1, en1} !== {1'b1, 3'd3, 1'b0, 5'b00000}) begin
                        failures++;
                        $display("FAIL watchdog_fault: fault=%b stage=%0d busy=%b en=%b", flt1, fs1, busy1, en1);
                    end
                end else if (v == 1 && mc == 9) begin
                    if ({flt1, en1} !== {1'b0, 5'b10000}) begin
                        failures++;
                        $display("FAIL watchdog_late_done: fault=%b en=%b want 0/10000", flt1, en1);
                    end
                end else if ({flt1, en1} !== {1'b0, 5'b01000}) begin
                    failures++;
                    $display("FAIL watchdog_wait mc %0d: fault=%b en=%b", mc, flt1, en1);
                end
                if (v == 1 && mc == 8) stage_done = 5'b01111;
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        run = 1'b1; stage_done = 5'b11111;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (en0 !== 5'b00100 && n < 20);
        #2 n_reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dout[k] !== 32'd0) begin
                failures++;
                $display("FAIL async_reset[%0d]: got %h want 00000000", k, dout[k]);
            end
        end
        @(negedge clk);
        n_reset = 1'b1; run = 1'b1;
        @(negedge clk);
        checks++;
        if ({en0, st0, ret0} !== {5'b00001, 5'b00001, 16'd0}) begin
            failures++;
            $display("FAIL async_restart: en=%b start=%b retired=%0d", en0, st0, ret0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dout[k] !== mexp(k)) begin
                    failures++;
                    $display("FAIL random[%0d] cyc %0d: got %h want %h", k, c, dout[k], mexp(k));
                end
            end
            run = ($urandom_range(0, 7) != 0);
            halt_req = ($urandom_range(0, 149) == 0);
            skip_mem = $urandom_range(0, 1) == 1;
            for (int b = 0; b < 5; b++) stage_done[b] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) stage_done = 5'b00000;
`ifdef SINGLE_STEP_EN
            step = $urandom_range(0, 1) == 1;
`endif
            n_reset = (c % 200 != 199);
        end
        n_reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_skip_mem();
        test_if_delay();
        test_halt();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Instruction-phase controller for the multi-cycle core. Replaces fixed-rate phase rotation with a handshaked one-hot sequence IF -> ID -> EX -> MEM -> WB.
- Each stage holds until its unit reports completion, so variable-latency memory is supported.
- Also provides MEM skip, halt, a per-stage watchdog and a retired-instruction counter.
- Sits between the top-level control and the stage units.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- TIMEOUT, 64, maximum cycles allowed in one stage before fault; 0 disables the watchdog.
- TMR_W, 8, width of the watchdog timer; must satisfy TIMEOUT <= 2^TMR_W.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- run  in  1  level; permits fetching of the next instruction.
- halt_req  in  1  request to stop after the current instruction retires.
- stage_done  in  5  per-stage completion; bit0=IF, 1=ID, 2=EX, 3=MEM, 4=WB.
- skip_mem  in  1  qualified by stage_done[2]; 1 = instruction has no memory access.
- stage_en  out  5  one-hot active-stage enable, same bit order.
- stage_start  out  5  one-cycle pulse on the first cycle of a stage.
- busy  out  1  high in any stage state.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- fault_stage  out  3  index of the stage that timed out.
- retired  out  CNT_W  count of completed WB stages.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (n_reset); all state is cleared immediately on assertion, including mid-instruction.
- Reset values:
  - state=IDLE.
  - stage_en=0, stage_start=0.
  - busy=0, halted=0, fault=0, fault_stage=0.
  - retired=0, timer=0, halt_pending=0.
- States: IDLE, IF, ID, EX, MEM, WB, HALT, FAULT. All outputs are registered.
- IDLE:
  - halt_req=1 -> HALT (has priority over run).
  - else run=1 -> IF.
  - else stay.
- Stage state S:
  - stage_en=onehot(S).
  - stage_start[S]=1 only on the entry cycle.
  - Advance on a rising edge where stage_done[S]=1. Done in the entry cycle is legal, giving a 1-cycle stage.
  - stage_done bits other than S are ignored.
- Stage order:
  - IF->ID, ID->EX, MEM->WB.
  - EX with done: skip_mem=1 -> WB, else -> MEM.
- WB with done:
  - retired <= retired+1, wrapping at 2^CNT_W.
  - Then, in priority order: (halt_pending | halt_req) -> HALT; run -> IF; else IDLE.
  - The IF re-entry is back-to-back: stage_start[0] is asserted on the next cycle.
- halt_pending: set by halt_req in any stage state; cleared on entering HALT. A halt never aborts a stage.
- Latency:
  - Minimum instruction time is 5 cycles with MEM, 4 with skip_mem.
  - IDLE->IF takes 1 cycle after run is sampled.
- Watchdog:
  - timer clears on every stage entry and increments each cycle in the stage without done.
  - If timer==TIMEOUT-1 and done=0 -> FAULT, with fault_stage=S.
  - Done in that same cycle wins over the timeout.
- HALT and FAULT are terminal until reset.
  - In both, stage_en=0 and stage_start=0.
  - halted=1 in HALT only; fault=1 in FAULT only.
- busy=1 exactly when state is one of IF..WB.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit, pulse).
  - IDLE->IF requires run & step.
  - WB completion always goes to IDLE, or to HALT if a halt is pending; it never chains directly to IF.
  - A step asserted outside IDLE is ignored.
- Undefined:
  - No step port.
  - Behaviour as above.

Test Plan:
- Reset, then run=1, stage_done=5'b11111 held -> stage_en sequences 00001,00010,00100,01000,10000, then 00001 again; retired increments every 5 cycles; retired=4 after 20 stage cycles.
- skip_mem=1 with EX done -> stage_en goes 00100 -> 10000; MEM is never enabled; period is 4 cycles/instruction.
- IF done delayed 10 cycles -> stage_en=00001 held for 11 cycles; stage_start[0] is high only in the first of them; no fault with TIMEOUT=64.
- halt_req pulsed during ID -> instruction completes through WB; then halted=1, stage_en=0; retired increments by exactly 1; further run has no effect.
- TIMEOUT=8, MEM never done -> fault=1 and fault_stage=3 on the 9th cycle after MEM entry; busy=0. A variant asserting done on the 8th cycle gives no fault.
- n_reset asserted mid-EX -> outputs return to reset values without waiting for a clock edge; after release, run=1 restarts at IF with retired=0.
